mcont_chn_scheduler: RTL and testbench

Round-robin channel scheduler for the memory controller's sequencer: it collects per-channel transfer requests, selects one channel at a time, and starts a sequence for it. It also holds the active channel number on the buffer-select bus for the full duration of the sequence and signals sequence completion back to the channel buffers. It sits between the channel request sources and the per-channel buffer registers, driving their channel-select, sequence-done and page-advance inputs.

---
 rtl/mcont_chn_scheduler.sv | 110 +++++++++++
 tb/tb_mcont_chn_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcont_chn_scheduler.sv
// Round-robin channel scheduler: picks one requesting channel at a time, runs a
// start/run/done handshake with the sequencer and reports completion to the buffers.
module mcont_chn_scheduler #(
    parameter int NUM_CHN = 16
) (
    input  logic               rst,
    input  logic               clk,
    input  logic [NUM_CHN-1:0] chn_en,
    input  logic [NUM_CHN-1:0] want_rq,
    input  logic [NUM_CHN-1:0] need_rq,
    input  logic               seq_ready,
    input  logic               seq_done,
    output logic               seq_start,
    output logic [3:0]         ext_buf_rchn,
    output logic               buf_done,
    output logic               ext_buf_rpage_nxt,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    // Sequencer handshake: seq_start stays high until seq_ready is sampled high
    // on a rising edge; that edge is the transfer. seq_done is honoured only in RUN.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [3:0]          last_chn;
    logic [NUM_CHN-1:0]  e_need;
    logic [NUM_CHN-1:0]  e_want;
    logic [15:0]         elig;
    logic [4:0]          idx;
    logic [3:0]          win;
    logic                found;

    assign e_need    = need_rq & chn_en;
    assign e_want    = want_rq & chn_en;
    assign state_dbg = state;

    // Urgent requests shadow normal ones entirely; search starts after last_chn.
    always_comb begin
        elig  = '0;
        idx   = '0;
        win   = '0;
        found = 1'b0;
        if (|e_need) begin
            elig[NUM_CHN-1:0] = e_need;
        end else begin
            elig[NUM_CHN-1:0] = e_want;
        end
        for (int i = 1; i <= NUM_CHN; i++) begin
            idx = {1'b0, last_chn} + 5'(i);
            if (idx >= 5'(NUM_CHN)) begin
                idx = idx - 5'(NUM_CHN);
            end
            if (!found && elig[idx[3:0]]) begin
                found = 1'b1;
                win   = idx[3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            seq_start         <= 1'b0;
            buf_done          <= 1'b0;
            ext_buf_rpage_nxt <= 1'b0;
            busy              <= 1'b0;
            ext_buf_rchn      <= 4'd0;
            last_chn          <= 4'(NUM_CHN - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        ext_buf_rchn <= win;
                        seq_start    <= 1'b1;
                        busy         <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    if (seq_ready) begin
                        seq_start <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (seq_done) begin
                        buf_done          <= 1'b1;
                        ext_buf_rpage_nxt <= 1'b1;
                        state             <= DONE;
                    end
                end
                DONE: begin
                    buf_done          <= 1'b0;
                    ext_buf_rpage_nxt <= 1'b0;
                    busy              <= 1'b0;
                    last_chn          <= ext_buf_rchn;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcont_chn_scheduler.sv
// Bench for mcont_chn_scheduler: a 16-channel and a 3-channel instance share the
// stimulus; grants are pushed to exp_q and checked when buf_done appears.
module tb_mcont_chn_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst3 = 1'b1;
    logic [15:0] chn_en = '1;
    logic [15:0] want_rq = '0;
    logic [15:0] need_rq = '0;
    logic        seq_ready = 1'b0;
    logic        seq_done = 1'b0;
    logic        sel = 1'b0;

    logic        s16_start, s16_done, s16_page, s16_busy;
    logic [3:0]  s16_rchn;
    logic [1:0]  s16_state;
    logic        s3_start, s3_done, s3_page, s3_busy;
    logic [3:0]  s3_rchn;
    logic [1:0]  s3_state;

    logic        m_start, m_done, m_page, m_busy;
    logic [3:0]  m_rchn;
    logic [1:0]  m_state;

    logic [3:0]  exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    mcont_chn_scheduler #(.NUM_CHN(16)) u16 (
        .rst(rst), .clk(clk), .chn_en(chn_en), .want_rq(want_rq), .need_rq(need_rq),
        .seq_ready(seq_ready), .seq_done(seq_done), .seq_start(s16_start),
        .ext_buf_rchn(s16_rchn), .buf_done(s16_done), .ext_buf_rpage_nxt(s16_page),
        .busy(s16_busy), .state_dbg(s16_state)
    );

    mcont_chn_scheduler #(.NUM_CHN(3)) u3 (
        .rst(rst3), .clk(clk), .chn_en(chn_en[2:0]), .want_rq(want_rq[2:0]),
        .need_rq(need_rq[2:0]), .seq_ready(seq_ready), .seq_done(seq_done),
        .seq_start(s3_start), .ext_buf_rchn(s3_rchn), .buf_done(s3_done),
        .ext_buf_rpage_nxt(s3_page), .busy(s3_busy), .state_dbg(s3_state)
    );

    assign m_start = sel ? s3_start : s16_start;
    assign m_done  = sel ? s3_done  : s16_done;
    assign m_page  = sel ? s3_page  : s16_page;
    assign m_busy  = sel ? s3_busy  : s16_busy;
    assign m_rchn  = sel ? s3_rchn  : s16_rchn;
    assign m_state = sel ? s3_state : s16_state;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every buf_done must match the oldest outstanding grant.
    always @(negedge clk) begin
        if (m_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_buf_done: got channel %0d expected none", m_rchn);
            end else begin
                check("grant_chn", m_rchn, exp_q.pop_front());
                check("page_nxt_with_done", m_page, 1);
            end
        end
    end

    task automatic do_reset(input logic use3);
        rst  = 1'b1;
        rst3 = 1'b1;
        repeat (2) @(negedge clk);
        sel = use3;
        if (use3) rst3 = 1'b0;
        else      rst  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Plays the sequencer: holds seq_ready low rdly cycles, then signals done ddly
    // cycles into RUN. glitch drops the requests and pulses seq_done inside START.
    task automatic run_seq(input int rdly, input int ddly, input bit glitch);
        bit         ok;
        bit         stable;
        int         cnt;
        int         dc0;
        logic [3:0] ch0;
        wait_start(ok);
        check("start_seen", ok, 1);
        if (!ok) return;
        ch0    = m_rchn;
        stable = 1'b1;
        cnt    = 0;
        dc0    = done_cnt;
        while (m_start && cnt < 50) begin
            cnt++;
            if (m_rchn !== ch0) stable = 1'b0;
            seq_ready = (cnt > rdly);
            seq_done  = glitch && (cnt == 2);
            if (glitch && cnt == 1) begin
                want_rq = '0;
                need_rq = '0;
            end
            @(negedge clk);
        end
        seq_ready = 1'b0;
        seq_done  = 1'b0;
        check("start_len", cnt, rdly + 1);
        if (rdly > 0) check("rchn_stable", stable, 1);
        check("busy_run", m_busy, 1);
        repeat (ddly) @(negedge clk);
        check("no_early_done", done_cnt, dc0);
        seq_done = 1'b1;
        @(negedge clk);
        seq_done = 1'b0;
        @(negedge clk);
        check("done_width", m_done, 0);
        check("idle_after", m_state, 0);
        check("busy_idle", m_busy, 0);
        check("done_count", done_cnt, dc0 + 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        bit ok;
        do_reset(1'b0);
        check("rst_seq_start", s16_start, 0);
        check("rst_busy", s16_busy, 0);
        check("rst_buf_done", s16_done, 0);
        check("rst_page", s16_page, 0);
        check("rst_rchn", s16_rchn, 0);
        check("rst_state", s16_state, 0);

        // Single request on channel 5
        want_rq = 16'h0020;
        exp_q.push_back(4'd5);
        run_seq(0, 3, 1'b0);
        want_rq = '0;

        // Round-robin between 3 and 9
        do_reset(1'b0);
        want_rq = 16'h0208;
        exp_q.push_back(4'd3); exp_q.push_back(4'd9);
        exp_q.push_back(4'd3); exp_q.push_back(4'd9);
        repeat (4) run_seq(0, 1, 1'b0);
        want_rq = '0;

        // First search after reset begins at channel 0
        do_reset(1'b0);
        want_rq = 16'h8001;
        exp_q.push_back(4'd0); exp_q.push_back(4'd15);
        repeat (2) run_seq(0, 0, 1'b0);
        want_rq = '0;

        // need beats want
        do_reset(1'b0);
        want_rq = 16'h0004;
        need_rq = 16'h0080;
        exp_q.push_back(4'd7);
        run_seq(0, 1, 1'b0);
        need_rq = '0;
        exp_q.push_back(4'd2);
        run_seq(0, 1, 1'b0);
        want_rq = '0;

        // Masked urgent request is never granted
        do_reset(1'b0);
        chn_en  = 16'hff7f;
        want_rq = 16'h0004;
        need_rq = 16'h0080;
        exp_q.push_back(4'd2); exp_q.push_back(4'd2);
        repeat (2) run_seq(0, 1, 1'b0);
        want_rq = '0;
        need_rq = '0;
        chn_en  = '1;

        // Backpressure, stray seq_done in START, request dropped after grant
        do_reset(1'b0);
        want_rq = 16'h0040;
        exp_q.push_back(4'd6);
        run_seq(5, 2, 1'b1);

        // Reset in the middle of RUN
        do_reset(1'b0);
        want_rq = 16'h0010;
        exp_q.push_back(4'd4);
        wait_start(ok);
        check("rstrun_start_seen", ok, 1);
        seq_ready = 1'b1;
        @(negedge clk);
        seq_ready = 1'b0;
        check("rstrun_in_run", s16_state, 2);
        check("rstrun_rchn", s16_rchn, 4);
        dc0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("rstrun_seq_start", s16_start, 0);
        check("rstrun_busy", s16_busy, 0);
        check("rstrun_buf_done", s16_done, 0);
        check("rstrun_page", s16_page, 0);
        check("rstrun_rchn0", s16_rchn, 0);
        check("rstrun_state", s16_state, 0);
        exp_q.delete();
        seq_done = 1'b1;
        @(negedge clk);
        seq_done = 1'b0;
        want_rq = 16'h0012;
        @(negedge clk);
        rst = 1'b0;
        check("rstrun_no_done", done_cnt, dc0);
        exp_q.push_back(4'd1);
        run_seq(0, 1, 1'b0);
        want_rq = '0;

        // Three-channel instance wraps 0,1,2,0
        do_reset(1'b1);
        check("n3_rst_rchn", s3_rchn, 0);
        want_rq = 16'h0007;
        exp_q.push_back(4'd0); exp_q.push_back(4'd1);
        exp_q.push_back(4'd2); exp_q.push_back(4'd0);
        repeat (4) run_seq(0, 0, 1'b0);
        want_rq = '0;

        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
